// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioner.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int NUM_BTN = 5;

    localparam int BTN_L = 4;
    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_R = 1;
    localparam int BTN_C = 0;

    // Defaults assume the 6.25 MHz system clock.
    localparam int DEF_DEBOUNCE_CYCLES = 62500;
    localparam int DEF_PULSE_WIDTH     = 1;
    localparam int DEF_REPEAT_DELAY    = 3125000;
    localparam int DEF_REPEAT_PERIOD   = 1250000;

endpackage

// File: rtl/button_debounce_channel.sv
// One button: synchroniser, debounce FSM, pulse stretcher and,
// with BTN_AUTOREPEAT_EN defined, a hold-to-repeat counter.
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef BTN_AUTOREPEAT_EN
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
    parameter int PULSE_WIDTH     = DEF_PULSE_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(PULSE_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          s;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fire_press;
    logic          enter_held;
    logic          fire;
    logic [WW-1:0] wcnt_q;

    always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], btn_raw};
    end

    assign s = sync_q[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fire_press = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = HELD;
                    cnt_d      = '0;
                    fire_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Covers both a fresh press and a bounce back out of RELEASE_WAIT.
    assign enter_held = (state_d == HELD) && (state_q != HELD);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt_q;
    logic          armed_q;
    logic          stay_held;
    logic          rpt_hit;

    assign stay_held = (state_q == HELD) && (state_d == HELD);
    assign rpt_hit   = stay_held &&
                       (rcnt_q == (armed_q ? RW'(REPEAT_PERIOD - 1)
                                           : RW'(REPEAT_DELAY - 1)));

    // Frozen outside HELD; restarted whenever HELD is (re)entered.
    always_ff @(posedge clock) begin
        if (reset || enter_held) begin
            rcnt_q  <= '0;
            armed_q <= 1'b0;
        end else if (rpt_hit) begin
            rcnt_q  <= '0;
            armed_q <= 1'b1;
        end else if (stay_held) begin
            rcnt_q  <= rcnt_q + RW'(1);
        end
    end

    assign fire = fire_press | rpt_hit;
`else
    assign fire = fire_press;
`endif

    always_ff @(posedge clock) begin
        if (reset)               wcnt_q <= '0;
        else if (fire)           wcnt_q <= WW'(PULSE_WIDTH);
        else if (wcnt_q != '0)   wcnt_q <= wcnt_q - WW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            pulse <= (wcnt_q != '0);
            level <= (state_q == HELD) || (state_q == RELEASE_WAIT);
        end
    end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Five independent debounced button channels {L,U,D,R,C}.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module button_pulse_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_WIDTH     = DEF_PULSE_WIDTH,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_BTN-1:0]   btn_in,
    output logic [NUM_BTN-1:0]   btn_sp,
    output logic [NUM_BTN-1:0]   btn_db
);

    if (DEBOUNCE_CYCLES < 2 || PULSE_WIDTH < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_pulse_conditioner: illegal timing parameter");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BTN_AUTOREPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .PULSE_WIDTH     (PULSE_WIDTH)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (btn_in[i]),
            .pulse   (btn_sp[i]),
            .level   (btn_db[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner (DEBOUNCE=4, PW=1).
module tb_button_pulse_conditioner;

    localparam int DB = 4;
    localparam int PW = 1;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn_in = '0;
    logic [4:0] btn_sp;
    logic [4:0] btn_db;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .PULSE_WIDTH     (PW),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .btn_in (btn_in),
        .btn_sp (btn_sp),
        .btn_db (btn_db)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [4:0] sp;
        logic [4:0] db;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [4:0] db_prev = '0;

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic void expect_ev(int c, logic [4:0] sp, logic [4:0] db);
        ev_t e;
        e.c  = c;
        e.sp = sp;
        e.db = db;
        exp_q.push_back(e);
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: any pulse or level change is an observable event.
    always @(negedge clock) begin
        ev_t e;
        if (!reset && (btn_sp != '0 || btn_db != db_prev)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: cyc %0d sp=%b db=%b",
                         cyc, btn_sp, btn_db);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.c);
                chk("event_sp", int'(btn_sp), int'(e.sp));
                chk("event_db", int'(btn_db), int'(e.db));
            end
        end
        db_prev = btn_db;
    end

    initial begin
        logic [6:0] press_pat;
        logic [4:0] rel_pat;
        int k;

        press_pat = 7'b1111011;
        rel_pat   = 5'b01100;

        // reset state
        reset  = 1'b1;
        btn_in = '0;
        step(3);
        chk("reset_sp", int'(btn_sp), 0);
        chk("reset_db", int'(btn_db), 0);
        reset = 1'b0;
        step(3);

        // clean press/release on L
        btn_in[4] = 1'b1;
        expect_ev(cyc + 7, 5'b10000, 5'b10000);
        step(12);
        btn_in[4] = 1'b0;
        expect_ev(cyc + 7, 5'b00000, 5'b00000);
        step(10);

        // bouncing press on U: 1,1,0,1,1,1,1
        k = cyc;
        expect_ev(k + 10, 5'b01000, 5'b01000);
        for (int i = 0; i < 7; i++) begin
            btn_in[3] = press_pat[i];
            step(1);
        end
        step(6);
        btn_in[3] = 1'b0;
        expect_ev(cyc + 7, 5'b00000, 5'b00000);
        step(10);

        // D release with 2-cycle high bounce
        btn_in[2] = 1'b1;
        expect_ev(cyc + 7, 5'b00100, 5'b00100);
        step(10);
        k = cyc;
        expect_ev(k + 11, 5'b00000, 5'b00000);
        for (int i = 0; i < 5; i++) begin
            btn_in[2] = rel_pat[i];
            step(1);
        end
        step(12);

        // R and C together
        btn_in[1:0] = 2'b11;
        expect_ev(cyc + 7, 5'b00011, 5'b00011);
        step(10);
        btn_in[1:0] = 2'b00;
        expect_ev(cyc + 7, 5'b00000, 5'b00000);
        step(10);

        // reset in the middle of PRESS_WAIT, button kept held
        btn_in[4] = 1'b1;
        step(4);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("in_reset_sp", int'(btn_sp), 0);
            chk("in_reset_db", int'(btn_db), 0);
        end
        reset = 1'b0;
        expect_ev(cyc + 7, 5'b10000, 5'b10000);
        step(10);
        btn_in[4] = 1'b0;
        expect_ev(cyc + 7, 5'b00000, 5'b00000);
        step(10);

        // long hold on L
        k = cyc;
        btn_in[4] = 1'b1;
        expect_ev(k + 7, 5'b10000, 5'b10000);
`ifdef BTN_AUTOREPEAT_EN
        expect_ev(k + 7 + RD,          5'b10000, 5'b10000);
        expect_ev(k + 7 + RD + RP,     5'b10000, 5'b10000);
        expect_ev(k + 7 + RD + 2 * RP, 5'b10000, 5'b10000);
        expect_ev(k + 7 + RD + 3 * RP, 5'b10000, 5'b10000);
        expect_ev(k + 7 + RD + 4 * RP, 5'b10000, 5'b10000);
`endif
        step(60);
        btn_in[4] = 1'b0;
        expect_ev(cyc + 7, 5'b00000, 5'b00000);
        step(14);

        chk("events_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_pulse_conditioner.md
# button_pulse_conditioner

Front-end conditioner for the five board push-buttons, sitting directly upstream of the dungeon room controller and the room mini-games. It synchronises the raw button levels into the 6.25 MHz domain, debounces each one independently, and produces two outputs per button. The single-pulse (`_SP`) outputs drive room navigation and game start/stop. The debounced-level outputs serve games that poll held buttons.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 62500: consecutive stable synchronised samples needed to accept a press or a release (10 ms at 6.25 MHz); must be ≥ 2.
- `PULSE_WIDTH`, 1: length in cycles of each `_SP` pulse; must be ≥ 1.
- `REPEAT_DELAY`, 3125000: hold time before the first auto-repeat pulse (only with the macro).
- `REPEAT_PERIOD`, 1250000: interval between auto-repeat pulses (only with the macro).

Ports:
- `clock`  in  1  6.25 MHz system clock; the block uses this single clock only.
- `reset`  in  1  synchronous, active-high reset.
- `btn_in`  in  5  raw asynchronous button levels, ordered {L,U,D,R,C} from bit 4 down to bit 0.
- `btn_sp`  out  5  registered single-pulse per button, same order.
- `btn_db`  out  5  registered debounced level per button, same order.

## Operation
- Each bit has its own independent channel; channels share nothing except `clock` and `reset`.
- Two-flop synchroniser per bit; all decisions use the second-stage output `s`.
- Per-channel state machine with a debounce counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`:
  - IDLE: `cnt`=0. On `s`=1, go to PRESS_WAIT with `cnt`=1.
  - PRESS_WAIT: on `s`=1, `cnt`++. When `cnt`==DEBOUNCE_CYCLES-1 and `s`=1, go to HELD and fire a pulse. On `s`=0, return to IDLE with `cnt` cleared.
  - HELD: on `s`=0, go to RELEASE_WAIT with `cnt`=1.
  - RELEASE_WAIT: on `s`=0, `cnt`++. When `cnt`==DEBOUNCE_CYCLES-1 and `s`=0, go to IDLE. On `s`=1, return to HELD with no new pulse.
- `btn_db`=1 exactly in HELD and RELEASE_WAIT.
- Pulse stretcher: a fire event loads a width counter with PULSE_WIDTH, and `btn_sp` stays high while that counter is non-zero. A fire event while already stretching reloads the counter, so overlapping pulses merge into one.
- Strobed consumers: a consumer that samples every N cycles sets PULSE_WIDTH=N so it sees each press exactly once.
- Simultaneous presses on several buttons produce `btn_sp` bits asserted in the same cycle. No priority is applied.

## Timing
- Reset: every `btn_sp`=0, every `btn_db`=0, synchroniser flops 0, all channels IDLE, all counters 0. Reset asserted mid-debounce or mid-pulse aborts it immediately.
- A button already held when reset deasserts is treated as a new press and yields one pulse after the normal latency.
- Press latency: a raw rise that stays clean gives `btn_sp` and `btn_db` rising on the same edge, DEBOUNCE_CYCLES+2 cycles after the first `btn_in`=1 sample edge.
- Release latency: `btn_db` falls DEBOUNCE_CYCLES+2 cycles after the first clean raw-low sample. Release never produces a pulse.
- Glitch filtering: a glitch shorter than DEBOUNCE_CYCLES synchronised samples never changes `btn_db` and never pulses.
- Pulse length: each `btn_sp` pulse is exactly PULSE_WIDTH cycles, unless it is extended by a reload.
- Counters saturate and never wrap; `cnt` cannot exceed DEBOUNCE_CYCLES-1.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - In HELD, a per-channel repeat counter fires a pulse after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while the channel stays in HELD.
  - The repeat counter is cleared on entry to HELD.
  - The repeat counter is frozen in RELEASE_WAIT and cleared when RELEASE_WAIT bounces back to HELD.
- `BTN_AUTOREPEAT_EN` undefined: exactly one pulse per accepted press. The repeat counters and the REPEAT_* parameters have no effect and generate no logic.

## Structure
- Package `button_pkg` contains:
  - channel state enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - bit-index constants BTN_L=4, BTN_U=3, BTN_D=2, BTN_R=1, BTN_C=0;
  - default timing constants.
- Sub-module `button_debounce_channel`: one bit per instance, containing the synchroniser, state machine, pulse stretcher and optional repeat logic. The top instantiates it five times with a generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, PULSE_WIDTH=1, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset with `btn_in`=0 → all outputs 0. Then hold `btn_in[4]`=1 → `btn_sp[4]` high for exactly 1 cycle, 6 cycles after the first high sample; `btn_db[4]`=1 from that same cycle.
- `btn_in[3]` bouncing 1,1,0,1,1,1,1 and then held → exactly one pulse, fired on the 4th consecutive synchronised 1.
- Held `btn_in[2]` released with a 2-cycle high bounce inside the release window → `btn_db[2]` stays 1 through the bounce and falls 4 clean-low samples later; no extra pulse.
- `btn_in[1]` and `btn_in[0]` rising on the same cycle → `btn_sp`=5'b00011 on a single cycle.
- Reset asserted mid-PRESS_WAIT with the button still held → outputs 0 during reset; one pulse 6 cycles after reset release.
- With `BTN_AUTOREPEAT_EN`, hold `btn_in[4]` for 60 cycles → pulses at press, press+20, press+28, press+36, press+44 and press+52; without the macro, only one pulse.
